// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: LSB-first, one bit per clock, WIDTH cycles per add.
// Define SERIAL_ADDER_OVF_EN to build the two's-complement overflow flag; otherwise ovf is tied to 0.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   // state | meaning
   // IDLE  | waiting for start
   // RUN   | adding one bit per cycle, LSB first
   // DONE  | result valid for one cycle; start here chains a new add

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-2:0] res_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q, cout_q;
   logic [CW-1:0]    cnt_q;

   logic             accept, last_bit, s_bit, c_next;
   logic [WIDTH-1:0] res_full;

   assign accept   = start && (state_q != RUN);
   assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
   assign s_bit    = a_q[0] ^ b_q[0] ^ carry_q;
   assign c_next   = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
   // Partial result with the new bit entering at the MSB; on the last bit this is the full sum.
   assign res_full = {s_bit, res_q};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= 1'b0;
            cnt_q   <= '0;
         end else if (state_q == RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= c_next;
            res_q   <= res_full[WIDTH-1:1];
            cnt_q   <= cnt_q + CW'(1);
            if (last_bit) begin
               sum_q  <= res_full;
               cout_q <= c_next;
            end
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q;

   // carry_q is the carry into the MSB while the last bit is processed.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (last_bit) begin
         ovf_q <= carry_q ^ c_next;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule
